tree_disp_sequencer: RTL and testbench
======================================

Name: tree_disp_sequencer

Overview:
Animation and digit-scan controller for the Christmas-tree 7-segment display. It time-multiplexes one shared 4-bit pattern decoder across N_DIG common-anode digits. It also steps a 16-frame animation, so digit k shows pattern code (frame + k) mod 16, giving a rolling marquee of tree glyphs. It sits between the top-level board logic (run/step controls) and the pattern decoder plus anode drivers.

Parameters:
N_DIG, 4, number of multiplexed digits (2..8)
SCAN_DIV, 1000, clock cycles per digit slot (> BLANK_CYC)
BLANK_CYC, 2, cycles at start of each slot with all anodes off (>= 1, anti-ghosting)
FRAME_DIV, 50, full scan rounds per animation frame (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
run  in  1  level; 1 = animate continuously
step  in  1  single-cycle pulse; request one frame advance while run=0
code_out  out  4  pattern code to the shared decoder input
an_n  out  N_DIG  active-low one-hot anode enables
frame  out  4  current animation frame
frame_wrap  out  1  one-cycle pulse when frame wraps

Behaviour:
- One clock domain. Reset is synchronous, active-high: rst sampled high on a clk edge resets all state on that edge.
- Reset values: slot counter 0, digit index 0, round counter 0, frame 0, step-pending flag 0, state BLANK, an_n all ones, code_out 0, frame_wrap 0.
- Scan FSM has two states, BLANK and SHOW.
  - BLANK: an_n all ones for BLANK_CYC cycles, then go to SHOW.
  - SHOW: an_n bit[digit index] = 0 and all other bits 1, for SCAN_DIV-BLANK_CYC cycles.
  - Slot end: digit index increments, wrapping N_DIG-1 -> 0; next state is BLANK.
- code_out = (frame + digit index) mod 16, 4-bit wrap-around add. It is registered and valid throughout both BLANK and SHOW of its slot, so the decoder settles before the anode turns on.
- Round boundary: the slot end where digit index wraps to 0. Frame changes only at a round boundary, so all digits in one round use the same frame.
- run=1:
  - Round counter increments at each round boundary.
  - When it equals FRAME_DIV-1 at a boundary, it clears and frame increments mod 16.
- run=0: round counter is held at 0 and frame never advances on its own.
  - A step pulse sets the pending flag.
  - At the next round boundary the frame increments once and the flag clears.
  - Several steps in one round give a single advance.
  - A step in the same cycle as the boundary is accepted and applied at the following boundary.
- step while run=1 is ignored. Any pending flag is cleared when run rises.
- frame_wrap pulses for exactly one cycle, on the cycle after frame changes 15 -> 0.
- Changing run mid-round takes effect at the next round boundary. Scanning never stops, even with run=0.
- Reset mid-slot: the next cycle is BLANK, digit 0, frame 0, with no partial-slot artefacts.

Optional Feature:
- Macro: TREE_SEQ_REVERSE_EN.
- Defined: adds input port dir (1 bit).
  - dir=1 decrements frame mod 16 at each advance point.
  - frame_wrap pulses on 0 -> 15.
  - dir is sampled at the advance boundary.
- Undefined: no dir port; increment only, exactly as specified above.

Decomposition:
- Package tree_disp_pkg:
  - CODE_W = 4 and FRAME_LAST = 4'hF.
  - Scan-state enum {ST_BLANK, ST_SHOW}.
  - Function for the 4-bit wrap add used to form code_out.
- One sub-module, disp_tick_div: a parameterised modulo-N counter with a terminal-count pulse and a synchronous clear.
  - Instantiated for the slot counter (SCAN_DIV).
  - Instantiated for the round counter (FRAME_DIV), with clear driven by ~run.

Test Plan (N_DIG=4, SCAN_DIV=4, BLANK_CYC=1, FRAME_DIV=2):
- Reset release, run=0 -> cycle 0: an_n=1111, code_out=0. Cycles 1-3: an_n=1110, code_out=0. Cycle 4: an_n=1111. Cycles 5-7: an_n=1101, code_out=1.
- Scan order over 16 cycles -> digits 0,1,2,3 each active 3 cycles, codes 0,1,2,3. Exactly one an_n bit low at any time.
- run=1 from reset -> frame=1 at cycle 32; digit0 shows 1 and digit3 shows 4 in the next round. frame=2 at cycle 64.
- Frame wrap: force frame=15 via 15 steps, then one more advance -> frame=0 and frame_wrap high for exactly 1 cycle. Digit0 shows 0 and digit3 shows 3.
- run=0, two step pulses at cycles 3 and 6 -> single advance to frame=1 at cycle 16 boundary, no further change.
- rst asserted for 1 cycle while digit 2 in SHOW with frame=5 -> next cycle: an_n=1111, frame=0, digit 0, frame_wrap=0.

Source files
------------

// File: rtl/tree_disp_pkg.sv
// tree_disp_pkg
// Shared types and helpers for the Christmas-tree display sequencer.
//   CODE_W      width of a pattern code / animation frame
//   FRAME_LAST  last frame before the animation wraps
//   scan_state_e  digit-slot phase (anodes blanked or digit shown)
//   wrap_add    4-bit wrap-around add used to form the per-digit code
package tree_disp_pkg;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] FRAME_LAST = 4'hF;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_e;

  // Overflow out of bit 3 is dropped on purpose: codes roll 15 -> 0.
  function automatic logic [CODE_W-1:0] wrap_add(input logic [CODE_W-1:0] a,
                                                 input logic [CODE_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/disp_tick_div.sv
// disp_tick_div
// Modulo-N counter with a terminal-count pulse and a synchronous clear.
//   clk    system clock
//   rst    synchronous reset, active-high
//   i_clr  synchronous clear (wins over i_en)
//   i_en   count enable
//   o_cnt  current count, 0..N-1
//   o_tc   high in the enabled cycle whose count is N-1 (count then returns to 0)
module disp_tick_div
  import tree_disp_pkg::*;
#(
  parameter int N = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc  = i_en && (r_cnt == LAST);
  assign o_cnt = r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs; reset is tested inside the clocked
  // block because it is synchronous.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tree_disp_sequencer.sv
// tree_disp_sequencer
// Digit-scan and animation controller for the Christmas-tree 7-segment
// display. One shared pattern decoder is time-multiplexed across N_DIG
// common-anode digits; digit k shows code (frame + k) mod 16, and the frame
// steps through a 16-entry animation either continuously (run) or one frame
// per step request.
//   clk         system clock
//   rst         synchronous reset, active-high
//   run         level: 1 = animate continuously
//   step        one-cycle pulse: request a single frame advance while run=0
//   dir         (only with TREE_SEQ_REVERSE_EN) 1 = frame counts down
//   code_out    pattern code for the shared decoder (registered)
//   an_n        active-low one-hot anode enables, all ones while blanking
//   frame       current animation frame
//   frame_wrap  one-cycle pulse in the first cycle after the frame wraps
// Optional build macro: TREE_SEQ_REVERSE_EN adds the dir input.
module tree_disp_sequencer
  import tree_disp_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2,
  parameter int FRAME_DIV = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
`ifdef TREE_SEQ_REVERSE_EN
  input  logic              dir,
`endif
  output logic [CODE_W-1:0] code_out,
  output logic [N_DIG-1:0]  an_n,
  output logic [CODE_W-1:0] frame,
  output logic              frame_wrap
);

  localparam int DIG_W  = $clog2(N_DIG);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int RND_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(N_DIG - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);

  scan_state_e       r_state, w_state_nxt;
  logic [DIG_W-1:0]  r_digit, w_digit_nxt;
  logic [CODE_W-1:0] r_frame, w_frame_nxt;
  logic [CODE_W-1:0] r_code;
  logic              r_pend;
  logic              r_wrap, w_wrap_nxt;

  logic [SLOT_W-1:0] w_slot_cnt;
  logic              w_slot_tc;
  logic [RND_W-1:0]  w_unused_round_cnt;  // only its terminal pulse matters
  logic              w_round_tc;
  logic              w_round_end;
  logic              w_adv;
  logic              w_dir;

`ifdef TREE_SEQ_REVERSE_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  // Free-running slot timer: counts 0..SCAN_DIV-1, blanking occupies the
  // first BLANK_CYC counts, the terminal count is the slot end.
  disp_tick_div #(.N(SCAN_DIV)) u_slot_div (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_en  (1'b1),
    .o_cnt (w_slot_cnt),
    .o_tc  (w_slot_tc)
  );

  // Counts completed scan rounds; held at 0 whenever run is low.
  disp_tick_div #(.N(FRAME_DIV)) u_round_div (
    .clk   (clk),
    .rst   (rst),
    .i_clr (~run),
    .i_en  (w_round_end),
    .o_cnt (w_unused_round_cnt),
    .o_tc  (w_round_tc)
  );

  assign w_round_end = w_slot_tc && (r_digit == DIG_LAST);
  // Frame moves only at a round boundary so a whole round shares one frame.
  assign w_adv = w_round_end && (run ? w_round_tc : r_pend);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_frame_nxt = r_frame;
    w_wrap_nxt  = 1'b0;
    an_n        = '1;

    case (r_state)
      ST_BLANK: begin
        if (w_slot_cnt == BLANK_LAST) w_state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        an_n[r_digit] = 1'b0;
        if (w_slot_tc) begin
          w_state_nxt = ST_BLANK;
          w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase

    if (w_adv) begin
      if (w_dir) begin
        w_frame_nxt = r_frame - CODE_W'(1);
        w_wrap_nxt  = (r_frame == '0);
      end else begin
        w_frame_nxt = r_frame + CODE_W'(1);
        w_wrap_nxt  = (r_frame == FRAME_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_digit <= '0;
      r_frame <= '0;
      r_code  <= '0;
      r_pend  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_frame <= w_frame_nxt;
      r_wrap  <= w_wrap_nxt;
      // Formed from next-state values so the decoder input is already stable
      // during the blanking cycles of the slot it belongs to.
      r_code  <= wrap_add(w_frame_nxt, CODE_W'(w_digit_nxt));
      // A step landing on the boundary cycle is kept for the next boundary.
      if (run)              r_pend <= 1'b0;
      else if (w_round_end) r_pend <= step;
      else if (step)        r_pend <= 1'b1;
    end
  end

  assign code_out   = r_code;
  assign frame      = r_frame;
  assign frame_wrap = r_wrap;

endmodule

// File: tb/tb_tree_disp_sequencer.sv
// Self-checking bench for tree_disp_sequencer with N_DIG=4, SCAN_DIV=4,
// BLANK_CYC=1, FRAME_DIV=2 (one scan round = 16 cycles).
// Stimulus pushes cycle-stamped expectations into a queue; a monitor pops and
// compares them on the falling edge of the matching cycle.
module tb_tree_disp_sequencer;

  localparam int N_DIG     = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] code_out;
  logic [3:0] an_n;
  logic [3:0] frame;
  logic       frame_wrap;

  tree_disp_sequencer #(
    .N_DIG     (N_DIG),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .FRAME_DIV (FRAME_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .code_out   (code_out),
    .an_n       (an_n),
    .frame      (frame),
    .frame_wrap (frame_wrap)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge: cycle 0 is the first cycle after it.
  int cyc = 0;
  int ep  = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // sel bits: [3] an_n, [2] code_out, [1] frame, [0] frame_wrap
  typedef struct {
    int         cyc;
    int         ep;
    string      name;
    logic [3:0] sel;
    logic [3:0] an;
    logic [3:0] code;
    logic [3:0] fr;
    logic       wr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int e, input string n, input logic [3:0] sel,
                      input logic [3:0] an, input logic [3:0] code,
                      input logic [3:0] fr, input logic wr);
    exp_t x;
    x.cyc = c; x.ep = e; x.name = n; x.sel = sel;
    x.an = an; x.code = code; x.fr = fr; x.wr = wr;
    q.push_back(x);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && (q[0].ep < ep || (q[0].ep == ep && q[0].cyc <= cyc))) begin
        e = q.pop_front();
        if (e.ep != ep || e.cyc != cyc) begin
          total++;
          bad++;
          $display("FAIL %s: expectation for cycle %0d never reached (now %0d)", e.name, e.cyc, cyc);
        end else begin
          if (e.sel[3]) check({e.name, ".an_n"}, an_n, e.an);
          if (e.sel[2]) check({e.name, ".code_out"}, code_out, e.code);
          if (e.sel[1]) check({e.name, ".frame"}, frame, e.fr);
          if (e.sel[0]) check({e.name, ".frame_wrap"}, {3'b0, frame_wrap}, {3'b0, e.wr});
        end
      end
    end
  end

  // Returns 1 cycle after the reset edge (cycle 0, just after the clock edge).
  task automatic do_reset(input logic run_val);
    @(posedge clk); #1;
    rst = 1'b1;
    ep++;
    run = run_val;
    step = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc != c && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (cyc != c) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: got cycle %0d want %0d", cyc, c);
    end
  endtask

  task automatic pulse_step(input int c);
    wait_cyc(c);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] one;

    // 1: reset state and scan order, run=0
    do_reset(1'b0);
    one = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      a = (c % 4 == 0) ? 4'hF : ~(one << (c / 4));
      push(c, ep, "scan", 4'b1111, a, 4'(c / 4), 4'h0, 1'b0);
    end
    push(40, ep, "hold_run0", 4'b0010, 4'h0, 4'h0, 4'h0, 1'b0);
    drain();

    // 2: run=1 from reset, frame advances every FRAME_DIV rounds
    do_reset(1'b1);
    push(31, ep, "run_pre",   4'b0010, 4'h0, 4'h0, 4'h0, 1'b0);
    push(32, ep, "run_f1",    4'b0111, 4'h0, 4'h1, 4'h1, 1'b0);
    push(33, ep, "run_d0",    4'b1100, 4'hE, 4'h1, 4'h0, 1'b0);
    push(44, ep, "run_d3_bl", 4'b1100, 4'hF, 4'h4, 4'h0, 1'b0);
    push(45, ep, "run_d3",    4'b1100, 4'h7, 4'h4, 4'h0, 1'b0);
    push(63, ep, "run_f1b",   4'b0010, 4'h0, 4'h0, 4'h1, 1'b0);
    push(64, ep, "run_f2",    4'b0010, 4'h0, 4'h0, 4'h2, 1'b0);
    drain();

    // 3: step to frame 15, then one more advance wraps to 0
    do_reset(1'b0);
    for (int k = 1; k < 16; k++) push(16 * k, ep, "step_fr", 4'b0110, 4'h0, 4'(k), 4'(k), 1'b0);
    push(255, ep, "wrap_pre",  4'b0011, 4'h0, 4'h0, 4'hF, 1'b0);
    push(256, ep, "wrap",      4'b0111, 4'h0, 4'h0, 4'h0, 1'b1);
    push(257, ep, "wrap_end",  4'b1101, 4'hE, 4'h0, 4'h0, 1'b0);
    push(268, ep, "wrap_d3bl", 4'b1100, 4'hF, 4'h3, 4'h0, 1'b0);
    push(269, ep, "wrap_d3",   4'b1100, 4'h7, 4'h3, 4'h0, 1'b0);
    for (int k = 0; k < 16; k++) pulse_step(16 * k + 2);
    drain();

    // 4: two steps in one round give one advance; boundary step is deferred
    do_reset(1'b0);
    push(15, ep, "dbl_pre", 4'b0010, 4'h0, 4'h0, 4'h0, 1'b0);
    push(16, ep, "dbl_adv", 4'b0010, 4'h0, 4'h0, 4'h1, 1'b0);
    push(32, ep, "dbl_one", 4'b0010, 4'h0, 4'h0, 4'h1, 1'b0);
    push(48, ep, "bnd_hold", 4'b0010, 4'h0, 4'h0, 4'h1, 1'b0);
    push(63, ep, "bnd_pre", 4'b0010, 4'h0, 4'h0, 4'h1, 1'b0);
    push(64, ep, "bnd_adv", 4'b0010, 4'h0, 4'h0, 4'h2, 1'b0);
    push(80, ep, "bnd_one", 4'b0010, 4'h0, 4'h0, 4'h2, 1'b0);
    pulse_step(3);
    pulse_step(6);
    pulse_step(47);
    drain();

    // 5: reset while digit 2 is shown with frame 5
    do_reset(1'b1);
    push(160, ep,     "mid_f5",  4'b0010, 4'h0, 4'h0, 4'h5, 1'b0);
    push(169, ep,     "mid_d2",  4'b1110, 4'hB, 4'h7, 4'h5, 1'b0);
    push(0,   ep + 1, "post_rst", 4'b1111, 4'hF, 4'h0, 4'h0, 1'b0);
    push(1,   ep + 1, "post_d0", 4'b1110, 4'hE, 4'h0, 4'h0, 1'b0);
    wait_cyc(169);
    @(negedge clk); #1;
    rst = 1'b1;
    ep++;
    @(posedge clk); #1;
    rst = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
